// File: rtl/led_pkg.sv
// Shared definitions for the LED breathing sequencer and the PWM stage checker.
// Holds the channel/width defaults, the sequencer state encoding and the triangle shaper.
package led_pkg;

    localparam int CHANNELS_DEFAULT = 6;
    localparam int DUTY_W_DEFAULT   = 8;

    // Widest duty the triangle helper supports; callers truncate to their own width.
    localparam int TRI_MAX_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } seq_state_t;

    // Bit w of p selects the falling half, where the low w bits are mirrored.
    function automatic logic [TRI_MAX_W-1:0] tri_wave(input logic [TRI_MAX_W:0] p, input int w);
        logic [TRI_MAX_W-1:0] ones;
        logic [TRI_MAX_W-1:0] mask;
        logic [TRI_MAX_W-1:0] low;
        ones = '1;
        mask = ~(ones << w);
        low  = p[TRI_MAX_W-1:0] & mask;
        return p[w[4:0]] ? (~low & mask) : low;
    endfunction

endpackage

// File: rtl/step_prescaler.sv
// Divides the system clock down to one-cycle brightness step ticks.
module step_prescaler #(
    parameter int DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    assign tick = !clear && (count == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/led_breath_seq.sv
// Phase-offset triangle-wave duty sequencer; new duties are released only at PWM period ends.
module led_breath_seq
    import led_pkg::*;
#(
    parameter int CHANNELS   = CHANNELS_DEFAULT,
    parameter int DUTY_W     = DUTY_W_DEFAULT,
    parameter int STEP_DIV   = 100000,
    parameter int PHASE_STEP = 42
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       period_end,
    output logic [CHANNELS*DUTY_W-1:0] duty,
    output logic                       duty_upd,
    output logic                       dir,
    output logic                       overrun
);

    seq_state_t state;
    seq_state_t state_next;

    logic [DUTY_W:0]              pos;
    logic                         pending;
    logic                         pending_next;
    logic                         tick;
    logic                         apply;
    logic                         prescaler_clear;
    logic [CHANNELS*DUTY_W-1:0]   target;

    assign prescaler_clear = (state != RUN);
    assign apply           = period_end && pending;
    assign dir             = pos[DUTY_W];

    step_prescaler #(
        .DIV (STEP_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .clear (prescaler_clear),
        .tick  (tick)
    );

    // Draining forces an all-zero target so the LEDs go dark at a period boundary.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_target
        localparam logic [DUTY_W:0] OFFSET = (DUTY_W + 1)'(i * PHASE_STEP);
        logic [DUTY_W:0] phase_pos;
        assign phase_pos = pos + OFFSET;
        assign target[i*DUTY_W +: DUTY_W] = (state == DRAIN) ? '0
            : DUTY_W'(tri_wave((TRI_MAX_W + 1)'(phase_pos), DUTY_W));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A tick on the apply edge re-arms pending so the newer position is not lost.
    always_comb begin
        state_next   = state;
        pending_next = pending;
        unique case (state)
            IDLE:    if (en) state_next = RUN;
            RUN:     if (!en) state_next = DRAIN;
            DRAIN: begin
                if (period_end) begin
                    state_next = IDLE;
                end else if (en) begin
                    state_next = RUN;
                end
            end
            default: state_next = IDLE;
        endcase
        if (state == RUN && !en) begin
            pending_next = 1'b1;
        end else if (state == DRAIN) begin
            pending_next = !period_end;
        end else if (tick) begin
            pending_next = 1'b1;
        end else if (apply) begin
            pending_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pos      <= '0;
            pending  <= 1'b0;
            duty     <= '0;
            duty_upd <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            pending  <= pending_next;
            duty_upd <= apply;
            if (tick) begin
                pos <= pos + 1'b1;
            end
            if (apply) begin
                duty <= target;
            end
            if (tick && pending && !period_end) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_led_breath_seq.sv
// Self-checking bench for led_breath_seq against a cycle-level behavioural model.
module tb_led_breath_seq;

    localparam int CH   = 6;
    localparam int W    = 4;
    localparam int DIV  = 4;
    localparam int PH   = 5;
    localparam int NPOS = 32;
    localparam int MAXV = 15;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            en = 1'b0;
    logic            period_end = 1'b0;
    logic [CH*W-1:0] duty;
    logic            duty_upd;
    logic            dir;
    logic            overrun;

    int n_checks = 0;
    int n_fail = 0;

    int m_state;
    int m_pos;
    int m_cnt;
    int m_duty [CH];
    bit m_pending;
    bit m_upd;
    bit m_overrun;

    led_breath_seq #(
        .CHANNELS   (CH),
        .DUTY_W     (W),
        .STEP_DIV   (DIV),
        .PHASE_STEP (PH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .period_end (period_end),
        .duty       (duty),
        .duty_upd   (duty_upd),
        .dir        (dir),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Brightness of a position on the 0..15..0 ramp, straight from the triangle rule.
    function automatic int tri_ref(input int p);
        int q;
        q = p % NPOS;
        return (q <= MAXV) ? q : (NPOS - 1 - q);
    endfunction

    function automatic logic [CH*W-1:0] exp_duty();
        logic [CH*W-1:0] r;
        for (int i = 0; i < CH; i++) r[i*W +: W] = W'(m_duty[i]);
        return r;
    endfunction

    function automatic logic [CH*W-1:0] targets_at(input int p);
        logic [CH*W-1:0] r;
        for (int i = 0; i < CH; i++) r[i*W +: W] = W'(tri_ref(p + i * PH));
        return r;
    endfunction

    function automatic bit m_dir();
        return m_pos >= 16;
    endfunction

    // Advance the reference by one clock edge using the inputs currently driven.
    task automatic model_edge();
        bit tick;
        bit apply;
        if (rst) begin
            m_state = M_IDLE; m_pos = 0; m_cnt = 0; m_pending = 0;
            m_upd = 0; m_overrun = 0;
            for (int i = 0; i < CH; i++) m_duty[i] = 0;
            return;
        end
        tick  = (m_state == M_RUN) && (m_cnt == DIV - 1);
        apply = period_end && m_pending;
        m_upd = apply;
        if (apply) begin
            for (int i = 0; i < CH; i++)
                m_duty[i] = (m_state == M_DRAIN) ? 0 : tri_ref(m_pos + i * PH);
        end
        if (tick && m_pending && !period_end) m_overrun = 1;
        if (m_state == M_RUN && !en) m_pending = 1;
        else if (m_state == M_DRAIN) m_pending = !period_end;
        else if (tick) m_pending = 1;
        else if (apply) m_pending = 0;
        m_cnt = (m_state == M_RUN && !tick) ? m_cnt + 1 : 0;
        if (tick) m_pos = (m_pos + 1) % NPOS;
        case (m_state)
            M_IDLE:  if (en) m_state = M_RUN;
            M_RUN:   if (!en) m_state = M_DRAIN;
            default: m_state = period_end ? M_IDLE : (en ? M_RUN : M_DRAIN);
        endcase
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; period_end = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; period_end = 1'b1;
        step();
        step();
        n_checks++;
        if (duty !== '0) begin n_fail++; $display("[TB] FAIL reset_duty: got %h want 0", duty); end
        n_checks++;
        if (duty_upd !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_upd: got %b want 0", duty_upd); end
        n_checks++;
        if (dir !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_dir: got %b want 0", dir); end
        n_checks++;
        if (overrun !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_overrun: got %b want 0", overrun); end
        rst = 1'b0; en = 1'b0; period_end = 1'b0;
    endtask

    task automatic test_first_update();
        bit seen;
        seen = 0;
        do_reset();
        en = 1'b1;
        for (int c = 0; c < 60 && !seen; c++) begin
            period_end = (c % 8 == 7);
            step();
            n_checks++;
            if (duty !== exp_duty() || duty_upd !== m_upd || dir !== m_dir() || overrun !== m_overrun) begin
                n_fail++;
                $display("[TB] FAIL first_update cycle: got duty=%h upd=%b dir=%b ovr=%b, want duty=%h upd=%b dir=%b ovr=%b",
                         duty, duty_upd, dir, overrun, exp_duty(), m_upd, m_dir(), m_overrun);
            end
            if (duty_upd === 1'b1) begin
                seen = 1;
                n_checks++;
                if (duty !== targets_at(1)) begin
                    n_fail++;
                    $display("[TB] FAIL first_update_pos1: got %h want %h", duty, targets_at(1));
                end
            end
        end
        period_end = 1'b0;
        if (!seen) begin
            n_checks++; n_fail++;
            $display("[TB] FAIL first_update_timeout: got no strobe want one within 60 cycles");
        end
    endtask

    task automatic test_starve();
        int p;
        do_reset();
        en = 1'b1; period_end = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            n_checks++;
            if (duty !== '0 || duty_upd !== m_upd || dir !== m_dir() || overrun !== m_overrun) begin
                n_fail++;
                $display("[TB] FAIL starve cycle: got duty=%h upd=%b dir=%b ovr=%b, want duty=0 upd=%b dir=%b ovr=%b",
                         duty, duty_upd, dir, overrun, m_upd, m_dir(), m_overrun);
            end
        end
        n_checks++;
        if (overrun !== 1'b1) begin n_fail++; $display("[TB] FAIL starve_overrun: got %b want 1", overrun); end
        p = m_pos;
        period_end = 1'b1;
        step();
        period_end = 1'b0;
        n_checks++;
        if (duty_upd !== 1'b1 || duty !== targets_at(p)) begin
            n_fail++;
            $display("[TB] FAIL starve_apply: got duty=%h upd=%b want duty=%h upd=1", duty, duty_upd, targets_at(p));
        end
    endtask

    task automatic test_coincident();
        do_reset();
        en = 1'b1; period_end = 1'b0;
        for (int c = 0; c < 40 && m_pos != 1; c++) step();
        period_end = 1'b1;
        step();
        period_end = 1'b0;
        for (int c = 0; c < 40 && !(m_pos == 2 && m_cnt == DIV - 1); c++) begin
            step();
            n_checks++;
            if (duty !== exp_duty() || duty_upd !== m_upd || dir !== m_dir() || overrun !== m_overrun) begin
                n_fail++;
                $display("[TB] FAIL coincident cycle: got duty=%h upd=%b dir=%b ovr=%b, want duty=%h upd=%b dir=%b ovr=%b",
                         duty, duty_upd, dir, overrun, exp_duty(), m_upd, m_dir(), m_overrun);
            end
        end
        if (!(m_pos == 2 && m_cnt == DIV - 1)) begin
            n_checks++; n_fail++;
            $display("[TB] FAIL coincident_timeout: got pos=%0d want tick pending at pos 2", m_pos);
        end
        period_end = 1'b1;
        step();
        period_end = 1'b0;
        n_checks++;
        if (duty[W-1:0] !== 4'd2 || duty_upd !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL coincident_apply: got ch0=%0d upd=%b want ch0=2 upd=1", duty[W-1:0], duty_upd);
        end
        n_checks++;
        if (overrun !== 1'b0) begin n_fail++; $display("[TB] FAIL coincident_overrun: got %b want 0", overrun); end
        step();
        period_end = 1'b1;
        step();
        period_end = 1'b0;
        n_checks++;
        if (duty[W-1:0] !== 4'd3 || duty_upd !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL coincident_next: got ch0=%0d upd=%b want ch0=3 upd=1", duty[W-1:0], duty_upd);
        end
    endtask

    task automatic test_full_ramp();
        int strobes;
        int k;
        int want;
        strobes = 0;
        do_reset();
        en = 1'b1;
        for (int c = 0; c < 400 && strobes < 33; c++) begin
            period_end = m_pending && (m_state == M_RUN) && (m_cnt != DIV - 1);
            step();
            n_checks++;
            if (duty !== exp_duty() || duty_upd !== m_upd || dir !== m_dir() || overrun !== m_overrun) begin
                n_fail++;
                $display("[TB] FAIL ramp cycle: got duty=%h upd=%b dir=%b ovr=%b, want duty=%h upd=%b dir=%b ovr=%b",
                         duty, duty_upd, dir, overrun, exp_duty(), m_upd, m_dir(), m_overrun);
            end
            if (duty_upd === 1'b1) begin
                strobes++;
                k = strobes % NPOS;
                want = (k < 16) ? k : (31 - k);
                n_checks++;
                if (duty[W-1:0] !== W'(want) || dir !== (k >= 16)) begin
                    n_fail++;
                    $display("[TB] FAIL ramp_step %0d: got ch0=%0d dir=%b want ch0=%0d dir=%b",
                             strobes, duty[W-1:0], dir, want, (k >= 16));
                end
            end
        end
        period_end = 1'b0;
        n_checks++;
        if (strobes != 33) begin n_fail++; $display("[TB] FAIL ramp_count: got %0d strobes want 33", strobes); end
    endtask

    task automatic test_drain();
        bit got;
        int held;
        do_reset();
        en = 1'b1;
        for (int c = 0; c < 24; c++) begin
            period_end = (c % 8 == 7);
            step();
        end
        en = 1'b0;
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            period_end = (c % 8 == 5);
            step();
            n_checks++;
            if (duty !== exp_duty() || duty_upd !== m_upd || dir !== m_dir() || overrun !== m_overrun) begin
                n_fail++;
                $display("[TB] FAIL drain cycle: got duty=%h upd=%b dir=%b ovr=%b, want duty=%h upd=%b dir=%b ovr=%b",
                         duty, duty_upd, dir, overrun, exp_duty(), m_upd, m_dir(), m_overrun);
            end
            if (duty_upd === 1'b1) got = 1;
        end
        n_checks++;
        if (!got || duty !== '0) begin n_fail++; $display("[TB] FAIL drain_zero: got duty=%h strobe=%b want duty=0 strobe=1", duty, got); end
        held = m_pos;
        for (int c = 0; c < 6; c++) begin
            period_end = (c % 3 == 1);
            step();
        end
        n_checks++;
        if (duty !== '0 || duty_upd !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_hold: got duty=%h upd=%b want 0/0", duty, duty_upd); end
        en = 1'b1;
        got = 0;
        for (int c = 0; c < 40 && !got; c++) begin
            period_end = (c % 8 == 7);
            step();
            if (duty_upd === 1'b1) got = 1;
        end
        period_end = 1'b0;
        n_checks++;
        if (!got || duty !== targets_at(held + 1)) begin
            n_fail++;
            $display("[TB] FAIL drain_resume: got duty=%h strobe=%b want duty=%h strobe=1", duty, got, targets_at(held + 1));
        end
    endtask

    task automatic test_reset_collision();
        do_reset();
        en = 1'b1;
        for (int c = 0; c < 30; c++) begin
            period_end = (c % 8 == 7);
            step();
        end
        period_end = 1'b0;
        for (int c = 0; c < 40 && !m_pending; c++) step();
        rst = 1'b1; period_end = 1'b1;
        step();
        rst = 1'b0; period_end = 1'b0; en = 1'b0;
        n_checks++;
        if (duty !== '0 || duty_upd !== 1'b0 || dir !== 1'b0 || overrun !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_collision: got duty=%h upd=%b dir=%b ovr=%b want all 0", duty, duty_upd, dir, overrun);
        end
        step();
        n_checks++;
        if (duty_upd !== 1'b0 || duty !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_collision_after: got duty=%h upd=%b want 0/0", duty, duty_upd);
        end
    endtask

    task automatic test_random();
        do_reset();
        en = 1'b1;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 15) == 0) en = ~en;
            period_end = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 199) == 0);
            step();
            n_checks++;
            if (duty !== exp_duty() || duty_upd !== m_upd || dir !== m_dir() || overrun !== m_overrun) begin
                n_fail++;
                $display("[TB] FAIL random cycle %0d: got duty=%h upd=%b dir=%b ovr=%b, want duty=%h upd=%b dir=%b ovr=%b",
                         c, duty, duty_upd, dir, overrun, exp_duty(), m_upd, m_dir(), m_overrun);
            end
        end
        rst = 1'b0; period_end = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_update();
        test_starve();
        test_coincident();
        test_full_ramp();
        test_drain();
        test_reset_collision();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
